// File: rtl/phase_ctrl.sv
// Instruction phase sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives one-hot phase strobes and memory requests, and owns the PC and retire counter.
module phase_ctrl #(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [5:0]  op,
    input  logic        ife,
    input  logic [31:0] addr_i,
    input  logic        mem_ready,
    output logic [3:0]  start,
    output logic [31:0] pc_o,
    output logic        reg_update,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        busy,
    output logic        err,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    localparam logic [5:0] OP_SW  = 6'b010000;
    localparam logic [5:0] OP_LW  = 6'b010001;
    localparam logic [5:0] OP_BEQ = 6'b100000;
    localparam logic [5:0] OP_JMP = 6'b100001;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic        armed;
    logic        is_load;
    logic        next_load;
    logic [7:0]  wait_cnt;
    logic        boundary;
    logic        branch_taken;
    logic        set_err;
    logic        op_alu;
    logic        op_mem;
    logic        op_branch;

    always_comb begin
        op_alu    = (op[5:3] == 3'b000) && (op[2:0] <= 3'd5);
        op_mem    = (op == OP_SW) || (op == OP_LW);
        op_branch = (op == OP_BEQ) || (op == OP_JMP);
    end

    // Every instruction-ending path funnels through 'boundary' so the PC, retire
    // count and FETCH/IDLE choice are decided in exactly one place.
    always_comb begin
        next_state   = state;
        next_load    = is_load;
        boundary     = 1'b0;
        branch_taken = 1'b0;
        set_err      = 1'b0;
        case (state)
            S_IDLE: begin
                if (run && !err && armed) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: next_state = S_EXEC;
            S_EXEC: begin
                if (op_alu) begin
                    next_state = S_WB;
                end else if (op_mem) begin
                    next_state = S_MEM;
                    next_load  = (op == OP_LW);
                end else if (op_branch) begin
                    boundary     = 1'b1;
                    branch_taken = (op == OP_JMP) || ife;
                end else begin
                    next_state = S_IDLE;
                    set_err    = 1'b1;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (is_load) begin
                        next_state = S_WB;
                    end else begin
                        boundary = 1'b1;
                    end
                end else if (wait_cnt >= WAIT_LAST) begin
                    next_state = S_IDLE;
                    set_err    = 1'b1;
                end
            end
            S_WB:    boundary   = 1'b1;
            default: next_state = S_IDLE;
        endcase
        if (boundary) begin
            next_state = run ? S_FETCH : S_IDLE;
        end
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            armed      <= 1'b0;
            is_load    <= 1'b0;
            wait_cnt   <= '0;
            start      <= '0;
            pc_o       <= PC_RESET;
            reg_update <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            retired    <= '0;
        end else begin
            state   <= next_state;
            armed   <= 1'b1;
            is_load <= next_load;

            if (state != S_MEM) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            case (next_state)
                S_FETCH: start <= 4'b0001;
                S_EXEC:  start <= 4'b0010;
                S_MEM:   start <= 4'b0100;
                S_WB:    start <= 4'b1000;
                default: start <= 4'b0000;
            endcase

            busy       <= (next_state != S_IDLE);
            mem_rd     <= (next_state == S_MEM) && next_load;
            mem_wr     <= (next_state == S_MEM) && !next_load;
            reg_update <= (next_state == S_WB) || (state == S_WB);

            if (set_err) begin
                err <= 1'b1;
            end

            if (boundary) begin
                pc_o    <= branch_taken ? addr_i : pc_o + 32'd4;
                retired <= retired + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_phase_ctrl.sv
// Directed bench for phase_ctrl: walks ALU, memory, branch, timeout, bad-opcode
// and reset scenarios with hand-computed expectations.
module tb_phase_ctrl;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [5:0]  op;
    logic        ife;
    logic [31:0] addr_i;
    logic        mem_ready;
    logic [3:0]  start;
    logic [31:0] pc_o;
    logic        reg_update;
    logic        mem_rd;
    logic        mem_wr;
    logic        busy;
    logic        err;
    logic [15:0] retired;

    int total = 0;
    int bad   = 0;

    localparam logic [5:0] ADD = 6'b000000;
    localparam logic [5:0] SW  = 6'b010000;
    localparam logic [5:0] LW  = 6'b010001;
    localparam logic [5:0] BEQ = 6'b100000;
    localparam logic [5:0] JMP = 6'b100001;
    localparam logic [5:0] BAD = 6'b111111;

    phase_ctrl #(.PC_RESET(32'h0000_0000), .MEM_TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .op         (op),
        .ife        (ife),
        .addr_i     (addr_i),
        .mem_ready  (mem_ready),
        .start      (start),
        .pc_o       (pc_o),
        .reg_update (reg_update),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .busy       (busy),
        .err        (err),
        .retired    (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b1; run = 1'b0; op = ADD; ife = 1'b0; addr_i = '0; mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_start",   32'(start),      32'h0);
        chk("rst_pc",      pc_o,            32'h0);
        chk("rst_busy",    32'(busy),       32'h0);
        chk("rst_err",     32'(err),        32'h0);
        chk("rst_retired", 32'(retired),    32'h0);
        chk("rst_regupd",  32'(reg_update), 32'h0);
        chk("rst_mem",     32'({mem_rd, mem_wr}), 32'h0);
        step(); step();

        // ADD from pc 0
        rst_n = 1'b1; run = 1'b1; op = ADD;
        step(); chk("arm_idle_busy", 32'(busy), 32'h0); chk("arm_idle_start", 32'(start), 32'h0);
        step(); chk("add_fetch", 32'(start), 32'h1); chk("add_busy", 32'(busy), 32'h1);
        step(); chk("add_decode", 32'(start), 32'h0);
        step(); chk("add_exec", 32'(start), 32'h2);
        step(); chk("add_wb", 32'(start), 32'h8); chk("add_wb_regupd", 32'(reg_update), 32'h1);
        step(); chk("add_next_fetch", 32'(start), 32'h1); chk("add_pc", pc_o, 32'h4);
                chk("add_retired", 32'(retired), 32'h1); chk("add_regupd_hold", 32'(reg_update), 32'h1);

        // LW, ready on third MEM cycle
        op = LW;
        step(); chk("lw_decode_regupd", 32'(reg_update), 32'h0);
        step(); chk("lw_exec_rd", 32'(mem_rd), 32'h0);
        step(); chk("lw_mem1_rd", 32'(mem_rd), 32'h1); chk("lw_mem1_start", 32'(start), 32'h4);
        step(); chk("lw_mem2_rd", 32'(mem_rd), 32'h1);
        step(); chk("lw_mem3_rd", 32'(mem_rd), 32'h1);
        mem_ready = 1'b1;
        step(); mem_ready = 1'b0;
                chk("lw_wb_start", 32'(start), 32'h8); chk("lw_wb_rd", 32'(mem_rd), 32'h0);
                chk("lw_wb_regupd", 32'(reg_update), 32'h1);
        step(); chk("lw_pc", pc_o, 32'h8); chk("lw_retired", 32'(retired), 32'h2);

        // SW, ready on first MEM cycle
        op = SW;
        step(); step();
        step(); chk("sw_mem1_wr", 32'(mem_wr), 32'h1);
        mem_ready = 1'b1;
        step(); mem_ready = 1'b0;
                chk("sw_done_wr", 32'(mem_wr), 32'h0); chk("sw_no_wb", 32'(start), 32'h1);
                chk("sw_regupd", 32'(reg_update), 32'h0); chk("sw_pc", pc_o, 32'hC);
                chk("sw_retired", 32'(retired), 32'h3);

        // BEQ taken, then BEQ not taken with ife changing before EXEC exit
        op = BEQ; ife = 1'b1; addr_i = 32'h40;
        step(); step(); step(); chk("beq_taken_pc", pc_o, 32'h40);
        ife = 1'b1; addr_i = 32'h999;
        step(); step();
        ife = 1'b0; addr_i = 32'h80;
        step(); chk("beq_fall_pc", pc_o, 32'h44); chk("beq_retired", 32'(retired), 32'h5);

        // JMP chain and PC wrap
        op = JMP; ife = 1'b0; addr_i = 32'hFFFF_FFFC;
        step(); step(); step(); chk("jmp_top_pc", pc_o, 32'hFFFF_FFFC);
        addr_i = 32'h100;
        step(); step(); step(); chk("jmp_from_top_pc", pc_o, 32'h100);
        addr_i = 32'hFFFF_FFFC;
        step(); step(); step(); chk("jmp_top2_pc", pc_o, 32'hFFFF_FFFC);
        op = ADD;
        step(); step(); step(); step(); chk("add_wrap_pc", pc_o, 32'h0);
        chk("wrap_retired", 32'(retired), 32'h9);

        // run dropped during DECODE
        step(); run = 1'b0;
        step(); step();
        step(); chk("rundrop_busy", 32'(busy), 32'h0); chk("rundrop_start", 32'(start), 32'h0);
                chk("rundrop_pc", pc_o, 32'h4); chk("rundrop_retired", 32'(retired), 32'hA);
                chk("rundrop_regupd", 32'(reg_update), 32'h1);
        step(); chk("idle_regupd", 32'(reg_update), 32'h0); chk("idle_busy", 32'(busy), 32'h0);
        mem_ready = 1'b1;
        step(); mem_ready = 1'b0; chk("idle_ready_ignored", 32'({busy, mem_rd, mem_wr}), 32'h0);

        // SW timeout: 15 MEM cycles then IDLE with err
        op = SW; run = 1'b1;
        step(); step(); step();
        for (int i = 0; i < 15; i++) begin
            step(); chk($sformatf("sw_wait_wr%0d", i), 32'(mem_wr), 32'h1);
        end
        step(); chk("to_err", 32'(err), 32'h1); chk("to_wr", 32'(mem_wr), 32'h0);
                chk("to_busy", 32'(busy), 32'h0); chk("to_pc", pc_o, 32'h4);
                chk("to_retired", 32'(retired), 32'hA);
        step(); step(); chk("err_run_ignored", 32'({busy, start}), 32'h0);

        // Illegal opcode
        rst_n = 1'b0; #1; chk("rst_clear_err", 32'(err), 32'h0);
        step(); rst_n = 1'b1; op = BAD;
        step(); step(); step(); step();
        step(); chk("bad_err", 32'(err), 32'h1); chk("bad_retired", 32'(retired), 32'h0);
                chk("bad_pc", pc_o, 32'h0); chk("bad_busy", 32'(busy), 32'h0);

        // Async reset during MEM
        rst_n = 1'b0; #1;
        step(); rst_n = 1'b1; op = LW; run = 1'b1;
        step(); step(); step(); step();
        step(); chk("pre_rst_mem_rd", 32'(mem_rd), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rd",    32'(mem_rd), 32'h0);
        chk("async_busy",  32'(busy), 32'h0);
        chk("async_start", 32'(start), 32'h0);
        run = 1'b0;
        step(); rst_n = 1'b1;
        step(); step();
        chk("post_rst_pc", pc_o, 32'h0); chk("post_rst_retired", 32'(retired), 32'h0);
        chk("post_rst_busy", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
